// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared constants for the stopwatch core: BCD digit width, per-digit wrap
// limits and the encoding of the run/pause control state.
package stopwatch_pkg;

  localparam int BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_t;

  // Units digits wrap after 9; tens of seconds and tens of minutes after 5.
  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t TENS_MAX  = 4'd5;

  // Control state encoding, kept as plain constants for legacy tools.
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN    = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSED = 2'd2;

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Button inputs and display/status outputs of the stopwatch core.
// The master side drives the buttons and watches the digits; the slave side
// is the counting core itself.
interface stopwatch_bcd_counter_if import stopwatch_pkg::*; ();

  logic start_stop;
  logic clear;
  bcd_t cs_ones;
  bcd_t cs_tens;
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t min_ones;
  bcd_t min_tens;
  logic running;
  logic rollover;

  modport master (
    output start_stop, clear,
    input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    input  running, rollover
  );

  modport slave (
    input  start_stop, clear,
    output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    output running, rollover
  );

endinterface

// File: rtl/stopwatch_bcd_counter_digit.sv
// One BCD digit of the stopwatch chain. Counts 0..LIMIT on inc, wraps to 0
// and raises carry combinationally so a whole chain resolves in one cycle.
module bcd_digit_counter import stopwatch_pkg::*; #(
  parameter bcd_t LIMIT = DIGIT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic carry
);

  bcd_t value_q;
  bcd_t value_d;

  // Next digit value: clear has priority over an increment in the same cycle.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == LIMIT) ? bcd_t'(0) : value_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & (value_q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase and MM:SS.cc BCD counter. Synchronizes the two button
// levels, detects their rising edges, runs the IDLE/RUN/PAUSED control and
// a centisecond prescaler that drives a six-digit carry chain.
module stopwatch_bcd_counter import stopwatch_pkg::*; #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic clk,
  input  logic rst_n,
  stopwatch_bcd_counter_if.slave sw
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  // Bit 0 carries start_stop, bit 1 carries clear.
  logic [1:0] btn_sync1_q, btn_sync1_d;
  logic [1:0] btn_sync2_q, btn_sync2_d;
  logic [1:0] btn_prev_q,  btn_prev_d;
  logic [1:0] btn_edge;
  logic       start_edge;
  logic       clear_edge;

  logic [STATE_W-1:0] state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               rollover_q, rollover_d;
  logic               tick;

  bcd_t cs_ones_val, cs_tens_val, sec_ones_val, sec_tens_val;
  bcd_t min_ones_val, min_tens_val;
  logic [5:0] carry;

  // Two-flop synchronizer followed by a previous-value flop for edge detect.
  always_comb begin
    btn_sync1_d = {sw.clear, sw.start_stop};
    btn_sync2_d = btn_sync1_q;
    btn_prev_d  = btn_sync2_q;
    btn_edge    = btn_sync2_q & ~btn_prev_q;
    start_edge  = btn_edge[0];
    clear_edge  = btn_edge[1];
  end

  // Control FSM: clear always returns to IDLE and beats a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (clear_edge) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_edge) state_d = ST_RUN;
        ST_RUN:    if (start_edge) state_d = ST_PAUSED;
        ST_PAUSED: if (start_edge) state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler advances only in RUN and holds while paused so resume keeps phase.
  always_comb begin
    tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    if (clear_edge) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Rollover fires when a tick carries out of the top digit, unless cleared.
  always_comb begin
    rollover_d = tick & carry[5] & ~clear_edge;
  end

  // All control state, synchronizers and the rollover pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      btn_prev_q  <= '0;
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      rollover_q  <= 1'b0;
    end else begin
      btn_sync1_q <= btn_sync1_d;
      btn_sync2_q <= btn_sync2_d;
      btn_prev_q  <= btn_prev_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      rollover_q  <= rollover_d;
    end
  end

  bcd_digit_counter #(.LIMIT(DIGIT_MAX)) u_cs_ones (
    .clk(clk), .rst_n(rst_n), .clr(clear_edge), .inc(tick),
    .value(cs_ones_val), .carry(carry[0])
  );

  bcd_digit_counter #(.LIMIT(DIGIT_MAX)) u_cs_tens (
    .clk(clk), .rst_n(rst_n), .clr(clear_edge), .inc(carry[0]),
    .value(cs_tens_val), .carry(carry[1])
  );

  bcd_digit_counter #(.LIMIT(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(clear_edge), .inc(carry[1]),
    .value(sec_ones_val), .carry(carry[2])
  );

  bcd_digit_counter #(.LIMIT(TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(clear_edge), .inc(carry[2]),
    .value(sec_tens_val), .carry(carry[3])
  );

  bcd_digit_counter #(.LIMIT(DIGIT_MAX)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr(clear_edge), .inc(carry[3]),
    .value(min_ones_val), .carry(carry[4])
  );

  bcd_digit_counter #(.LIMIT(TENS_MAX)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(clear_edge), .inc(carry[4]),
    .value(min_tens_val), .carry(carry[5])
  );

  assign sw.cs_ones  = cs_ones_val;
  assign sw.cs_tens  = cs_tens_val;
  assign sw.sec_ones = sec_ones_val;
  assign sw.sec_tens = sec_tens_val;
  assign sw.min_ones = min_ones_val;
  assign sw.min_tens = min_tens_val;
  assign sw.running  = (state_q == ST_RUN);
  assign sw.rollover = rollover_q;

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Timebase and BCD counting core of the stopwatch. Converts the system clock into a centisecond tick and maintains six cascaded BCD digits (MM:SS.cc, max 59:59.99) under control of start/stop and clear buttons. Each digit output feeds one downstream BCD-to-seven-segment decoder directly.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency
- TICK_HZ, 100, count rate; DIV = CLK_FREQ_HZ/TICK_HZ must be an integer ≥ 2
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start_stop  in  1  debounced button level, asynchronous to clk; rising edge toggles run/pause
- clear  in  1  debounced button level, asynchronous to clk; rising edge zeroes the counter
- cs_ones, cs_tens  out  4 each  centiseconds, BCD 0–9 / 0–9
- sec_ones, sec_tens  out  4 each  seconds, BCD 0–9 / 0–5
- min_ones, min_tens  out  4 each  minutes, BCD 0–9 / 0–5
- running  out  1  high while in RUN
- rollover  out  1  one-cycle pulse on wrap from 59:59.99 to 00:00.00

One clock; reset is asynchronous and active-low.

## Operation
- Reset: all digits 0, prescaler 0, state IDLE, running=0, rollover=0, synchronizer and edge flops 0.
- Inputs: each button passes through a 2-flop synchronizer, then a previous-value flop; edge = sync2 & ~prev.
- States:
  - IDLE (digits zero): start edge → RUN.
  - RUN: start edge → PAUSED.
  - PAUSED: start edge → RUN.
  - Clear edge in any state → IDLE, digits and prescaler zeroed.
- Simultaneous start and clear edges: clear wins; state IDLE.
- Prescaler: counts 0..DIV-1 only in RUN and holds its value in PAUSED, so resume is phase-continuous. On DIV-1 it returns to 0 and generates an internal tick.
- Digit chain on tick: cs_ones increments. Each digit wraps at its limit (9, or 5 for tens of seconds and minutes) and carries into the next digit. All carries resolve in the same cycle.
- Wrap: at 59:59.99 the tick sets all digits to 0, pulses rollover for that cycle, and the block stays in RUN.
- Digits never leave legal BCD range. Values 10–15 are unreachable.

## Timing
- A button rising edge sampled at clk edge k is detected after sync2 updates at edge k+1. State and running change at edge k+2.
- First tick after entering RUN from IDLE occurs DIV clocks later. cs_ones becomes 1 at that edge.
- Digit outputs and rollover are registered and change only on clk edges. There is no combinational path from inputs to outputs.
- Clear takes effect at edge k+2 and overrides a tick coincident with that edge.
- rst_n assertion mid-count zeroes everything immediately, without waiting for a clock edge. Deassertion is synchronized externally; the first active edge follows the reset values.

## Structure
- Package stopwatch_pkg holds:
  - the BCD digit width (4)
  - digit limits (9, 5)
  - state encoding for IDLE/RUN/PAUSED
- Sub-module bcd_digit_counter:
  - parameter LIMIT
  - inputs: clk, rst_n, clr, inc
  - outputs: value[3:0], carry (inc & value==LIMIT)
  - instantiated six times in a carry chain
- Top-level holds the synchronizers, edge detection, FSM, and prescaler.

## Test plan
Use CLK_FREQ_HZ=1000 and TICK_HZ=100, so DIV=10.
- Reset then idle 100 clocks → all digits 0, running=0, rollover never asserted.
- Start pulse, then 10×DIV+2 clocks → running=1 two edges after the sync sample; cs_tens=1, cs_ones=0 (00:00.10).
- Run to 00:00.99, then one tick → digits 00:01.00; a carry chain of two digits in one cycle.
- Pause mid-prescale (prescaler=4), hold 50 clocks, resume → digits frozen while paused; next tick arrives exactly 6 clocks after resume takes effect.
- Preload-by-running to 59:59.99 → next tick gives 00:00.00, rollover high for exactly one cycle, running stays 1.
- Start and clear rising together while RUN at 00:12.34 → digits 00:00.00, state IDLE, running=0. Assert rst_n low mid-run → outputs zero with no clock edge.
